// File: rtl/encoder_frame_ctrl.sv
// rtl/encoder_frame_ctrl.sv - frame sequencer for the serial convolutional encoder
// Serialises a word MSB-first with K-1 zero tail bits and packs the encoder pairs into one frame.
module encoder_frame_ctrl #(
  parameter int DATA_W = 8,
  parameter int MAX_K  = 7
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  input  logic [2:0]                      choose_constraint_length,
  output logic                            enc_bit,
  input  logic [1:0]                      enc_out,
  output logic                            frame_valid,
  input  logic                            frame_ready,
  output logic [2*(DATA_W+MAX_K-1)-1:0]   frame_data,
  output logic [3:0]                      frame_len,
  output logic                            busy
);
  localparam int PAIRS = DATA_W + MAX_K - 1;
  localparam int CNT_W = $clog2(PAIRS + 1);

  typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_DATA, S_TAIL, S_DRAIN, S_HOLD} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic [CNT_W-1:0]  pidx;
  logic [CNT_W-1:0]  k_q;
  logic [CNT_W-1:0]  k_sel;
  logic [CNT_W:0]    pair_base;
  logic [7:0]        ccl_w;
  logic [DATA_W-1:0] sreg;
  logic              cap_en;

  // Out-of-range constraint lengths fall back to K=3.
  assign ccl_w     = {5'b0, choose_constraint_length};
  assign k_sel     = (ccl_w >= 8'd3 && ccl_w <= 8'(MAX_K)) ? CNT_W'(choose_constraint_length)
                                                           : CNT_W'(3);
  assign pair_base = {pidx, 1'b0};

  assign in_ready    = (state == S_IDLE);
  assign frame_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (flush_cnt <= CNT_W'(1)) state_nxt = S_IDLE;
      S_IDLE:  if (in_valid) state_nxt = S_DATA;
      S_DATA:  if (cnt == CNT_W'(DATA_W - 1)) state_nxt = S_TAIL;
      S_TAIL:  if (cnt == k_q - CNT_W'(2)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_HOLD;
      S_HOLD:  if (frame_ready) state_nxt = S_IDLE;
      default: state_nxt = S_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FLUSH;
      flush_cnt  <= CNT_W'(MAX_K - 1);
      cnt        <= '0;
      pidx       <= '0;
      k_q        <= CNT_W'(3);
      sreg       <= '0;
      cap_en     <= 1'b0;
      enc_bit    <= 1'b0;
      frame_data <= '0;
      frame_len  <= '0;
    end else begin
      state   <= state_nxt;
      enc_bit <= 1'b0;
      // The encoder output lags its input by one cycle, so capture trails DATA/TAIL.
      cap_en  <= (state == S_DATA) || (state == S_TAIL);
      if (state == S_FLUSH)
        flush_cnt <= flush_cnt - CNT_W'(1);
      if (cap_en) begin
        frame_data[pair_base +: 2] <= enc_out;
        pidx                       <= pidx + CNT_W'(1);
      end
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sreg       <= in_data;
            k_q        <= k_sel;
            frame_len  <= 4'(DATA_W - 1 + int'(k_sel));
            frame_data <= '0;
            pidx       <= '0;
            cnt        <= '0;
            enc_bit    <= in_data[DATA_W-1];
          end
        end
        S_DATA: begin
          sreg <= sreg << 1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            cnt <= '0;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            enc_bit <= sreg[DATA_W-2];
          end
        end
        S_TAIL:  cnt <= cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_encoder_frame_ctrl.sv
// tb/tb_encoder_frame_ctrl.sv - randomized self-checking bench for encoder_frame_ctrl
module tb_encoder_frame_ctrl;
  localparam int DATA_W = 8;
  localparam int MAX_K  = 7;
  localparam int FW     = 2 * (DATA_W + MAX_K - 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [2:0]        ccl = 3'd3;
  logic              enc_bit;
  logic [1:0]        enc_out = 2'b00;
  logic              frame_valid;
  logic              frame_ready = 1'b0;
  logic [FW-1:0]     frame_data;
  logic [3:0]        frame_len;
  logic              busy;
  logic              u1 = 1'b0, u2 = 1'b0;
  int                passed = 0, total = 0;

  always #5 clk = ~clk;

  encoder_frame_ctrl #(.DATA_W(DATA_W), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .choose_constraint_length(ccl), .enc_bit(enc_bit), .enc_out(enc_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_data(frame_data),
    .frame_len(frame_len), .busy(busy)
  );

  // encoder_k3 stand-in: out1 = u^u1^u2, out0 = u^u2, registered
  always @(posedge clk) begin
    enc_out <= {enc_bit ^ u1 ^ u2, enc_bit ^ u2};
    u2      <= u1;
    u1      <= enc_bit;
  end

  function automatic int k_eff(input int c);
    return (c >= 3 && c <= MAX_K) ? c : 3;
  endfunction

  function automatic logic bit_at(input logic [DATA_W-1:0] d, input int n);
    if (n < 0 || n >= DATA_W) return 1'b0;
    return d[DATA_W-1-n];
  endfunction

  // Frame as a convolution over the MSB-first bit stream followed by zero tail bits
  function automatic logic [FW-1:0] ref_frame(input logic [DATA_W-1:0] d, input int k);
    logic [FW-1:0] f;
    logic a, b, c;
    f = '0;
    for (int n = 0; n < DATA_W + k - 1; n++) begin
      a = bit_at(d, n);
      b = bit_at(d, n - 1);
      c = bit_at(d, n - 2);
      f[2*n+1] = a ^ b ^ c;
      f[2*n]   = a ^ c;
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [DATA_W-1:0] d, input logic [2:0] c, output int lat);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    in_data  = d;
    ccl      = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ccl      = 3'($urandom);
    lat      = 0;
    while (frame_valid !== 1'b1 && lat < 60) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
    total++; if (enc_bit !== 1'b0) $display("FAIL reset_enc_bit got=%b exp=0", enc_bit); else passed++;
    total++; if (frame_valid !== 1'b0) $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); else passed++;
    total++; if (frame_data !== '0) $display("FAIL reset_frame_data got=%h exp=0", frame_data); else passed++;
    total++; if (frame_len !== 4'd0) $display("FAIL reset_frame_len got=%0d exp=0", frame_len); else passed++;
    total++; if (busy !== 1'b1) $display("FAIL reset_busy got=%b exp=1", busy); else passed++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (in_ready !== 1'b0 || enc_bit !== 1'b0) bad++;
      tick();
    end
    total++; if (bad != 0) $display("FAIL reset_flush_window got=%0d bad cycles exp=0", bad); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_idle_ready got=%b exp=1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b exp=0", busy); else passed++;
  endtask

  task automatic test_impulse();
    int lat;
    run_frame(8'h80, 3'd3, lat);
    total++; if (lat != 11) $display("FAIL impulse_latency got=%0d exp=11", lat); else passed++;
    total++; if (frame_len !== 4'd10) $display("FAIL impulse_len got=%0d exp=10", frame_len); else passed++;
    total++; if (frame_data !== 28'h000003B) $display("FAIL impulse_data got=%h exp=000003b", frame_data); else passed++;
    release_frame();
  endtask

  task automatic test_all_ones();
    int lat;
    run_frame(8'hFF, 3'd3, lat);
    total++; if (frame_data !== 28'h00DAAA7) $display("FAIL ones_data got=%h exp=00daaa7", frame_data); else passed++;
    total++; if (frame_data !== ref_frame(8'hFF, 3)) $display("FAIL ones_model got=%h exp=%h", frame_data, ref_frame(8'hFF, 3)); else passed++;
    release_frame();
  endtask

  task automatic test_k5();
    int lat;
    run_frame(8'h80, 3'd5, lat);
    total++; if (lat != 13) $display("FAIL k5_latency got=%0d exp=13", lat); else passed++;
    total++; if (frame_len !== 4'd12) $display("FAIL k5_len got=%0d exp=12", frame_len); else passed++;
    total++; if (frame_data !== 28'h000003B) $display("FAIL k5_data got=%h exp=000003b", frame_data); else passed++;
    release_frame();
  endtask

  task automatic test_stall();
    int lat, bad;
    logic [DATA_W-1:0] d;
    logic [FW-1:0] exp;
    d   = DATA_W'($urandom);
    exp = ref_frame(d, 3);
    run_frame(d, 3'd3, lat);
    in_data  = ~d;
    in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (frame_valid !== 1'b1 || frame_data !== exp || in_ready !== 1'b0 || enc_bit !== 1'b0) bad++;
    end
    total++; if (bad != 0) $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); else passed++;
    in_valid    = 1'b0;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    total++; if (frame_valid !== 1'b0) $display("FAIL stall_release_valid got=%b exp=0", frame_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", in_ready); else passed++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL stall_word_consumed busy=%b exp=0", busy); else passed++;
  endtask

  task automatic test_rst_mid();
    int lat, bad_ready, seen_valid;
    in_data  = 8'hA5;
    ccl      = 3'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bad_ready  = 0;
    seen_valid = 0;
    for (int i = 0; i < 30; i++) begin
      if (i < 6 && in_ready !== 1'b0) bad_ready++;
      if (frame_valid !== 1'b0) seen_valid++;
      tick();
    end
    total++; if (seen_valid != 0) $display("FAIL rstmid_no_frame got=%0d valid cycles exp=0", seen_valid); else passed++;
    total++; if (bad_ready != 0) $display("FAIL rstmid_flush got=%0d ready cycles exp=0", bad_ready); else passed++;
    run_frame(8'h80, 3'd3, lat);
    total++; if (frame_data !== 28'h000003B) $display("FAIL rstmid_next_data got=%h exp=000003b", frame_data); else passed++;
    total++; if (lat != 11) $display("FAIL rstmid_next_latency got=%0d exp=11", lat); else passed++;
    release_frame();
  endtask

  task automatic test_illegal_k();
    int lat;
    for (int c = 0; c < 3; c++) begin
      run_frame(8'h80, 3'(c), lat);
      total++; if (frame_len !== 4'd10) $display("FAIL illegal_k%0d_len got=%0d exp=10", c, frame_len); else passed++;
      total++; if (lat != 11) $display("FAIL illegal_k%0d_latency got=%0d exp=11", c, lat); else passed++;
      release_frame();
    end
  endtask

  task automatic test_random();
    int lat, k, c;
    logic [DATA_W-1:0] d;
    for (int n = 0; n < 15; n++) begin
      d = DATA_W'($urandom);
      c = $urandom_range(0, 7);
      k = k_eff(c);
      run_frame(d, 3'(c), lat);
      total++; if (frame_data !== ref_frame(d, k)) $display("FAIL rand%0d_data d=%h k=%0d got=%h exp=%h", n, d, k, frame_data, ref_frame(d, k)); else passed++;
      total++; if (frame_len !== 4'(DATA_W + k - 1)) $display("FAIL rand%0d_len got=%0d exp=%0d", n, frame_len, DATA_W + k - 1); else passed++;
      total++; if (lat != DATA_W + k) $display("FAIL rand%0d_latency got=%0d exp=%0d", n, lat, DATA_W + k); else passed++;
      for (int w = $urandom_range(0, 3); w > 0; w--) tick();
      release_frame();
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] d;
    logic [FW-1:0] fd;
    logic acc, hs;
    int last_acc, min_gap, frames, bad, w;
    last_acc = -1;
    min_gap  = 1000;
    frames   = 0;
    bad      = 0;
    frame_ready = 1'b1;
    ccl         = 3'd3;
    in_data     = DATA_W'($urandom);
    in_valid    = 1'b1;
    for (int cyc = 0; cyc < 80; cyc++) begin
      acc = in_ready && in_valid;
      hs  = frame_valid && frame_ready;
      fd  = frame_data;
      tick();
      if (acc) begin
        q.push_back(in_data);
        if (last_acc >= 0 && cyc - last_acc < min_gap) min_gap = cyc - last_acc;
        last_acc = cyc;
        in_data  = DATA_W'($urandom);
      end
      if (hs) begin
        frames++;
        if (q.size() == 0) bad++;
        else begin
          d = q.pop_front();
          if (fd !== ref_frame(d, 3)) bad++;
        end
      end
    end
    in_valid = 1'b0;
    w = 0;
    while (busy !== 1'b0 && w < 60) begin
      tick();
      w++;
    end
    frame_ready = 1'b0;
    total++; if (frames < 5) $display("FAIL b2b_frames got=%0d exp>=5", frames); else passed++;
    total++; if (bad != 0) $display("FAIL b2b_data got=%0d bad frames exp=0", bad); else passed++;
    total++; if (min_gap < DATA_W + 3 + 1) $display("FAIL b2b_gap got=%0d exp>=%0d", min_gap, DATA_W + 4); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_drain busy=%b exp=0", busy); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_impulse();
    test_all_ones();
    test_k5();
    test_stall();
    test_rst_mid();
    test_illegal_k();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
